// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set controller: mode encodings,
// blink mask field indices, BCD field limits and bus widths.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } mode_e;

  localparam int unsigned HOUR_BIT = 2;
  localparam int unsigned MIN_BIT  = 1;
  localparam int unsigned SEC_BIT  = 0;

  localparam int unsigned SEC_MOD = 60;
  localparam int unsigned MIN_MOD = 60;

  localparam int unsigned BCD_W   = 8;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned FIELD_W = 3;

endpackage

// File: rtl/clock_set_controller_if.sv
// Button/tick inputs and display-side outputs of the clock controller.
//   master : drives tick, mode_btn, inc_btn; observes time, mode, blink, rollover
//   slave  : the controller itself
interface clock_set_controller_if;
  import clock_pkg::*;

  logic               tick;
  logic               mode_btn;
  logic               inc_btn;
  logic [BCD_W-1:0]   hours;
  logic [BCD_W-1:0]   minutes;
  logic [BCD_W-1:0]   seconds;
  logic [MODE_W-1:0]  mode;
  logic [FIELD_W-1:0] blink_hide;
  logic               day_rollover;

  modport master (
    output tick, mode_btn, inc_btn,
    input  hours, minutes, seconds, mode, blink_hide, day_rollover
  );

  modport slave (
    input  tick, mode_btn, inc_btn,
    output hours, minutes, seconds, mode, blink_hide, day_rollover
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD (2..99).
//   clk, reset (async active-low), inc : advance by one
//   value  : registered BCD {tens, units}
//   wrap_c : combinational, high when inc will wrap the counter to 00
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             wrap_c
);

  localparam logic [3:0] LAST_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] LAST_U = 4'((MOD - 1) % 10);

  logic [3:0] tens;
  logic [3:0] units;

  // BCD increment with terminal-count wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (wrap_c) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  assign value  = {tens, units};
  assign wrap_c = inc && (tens == LAST_T) && (units == LAST_U);

endmodule

// File: rtl/clock_set_controller.sv
// Timekeeping and time-set controller. Counts hh:mm:ss from a 1 Hz tick in
// RUN, lets the user select and step one field in the SET modes, and drives
// blink masks and a day-rollover pulse for the display.
//   clk, reset (async active-low)
//   bus : clock_set_controller_if.slave (tick/buttons in, time/mode/blink out)
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MOD = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  clock_set_controller_if.slave  bus
);

  mode_e              state;
  mode_e              state_next;
  logic               phase;
  logic               phase_next;
  logic [FIELD_W-1:0] blink_hide_q;
  logic [FIELD_W-1:0] hide_next;
  logic               day_rollover_q;
  logic               inc_accept;

  logic               sec_inc, min_inc, hr_inc;
  logic               sec_wrap, min_wrap, hr_wrap;
  logic [BCD_W-1:0]   sec_v, min_v, hr_v;

  // State, blink phase and registered display flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      phase          <= 1'b0;
      blink_hide_q   <= '0;
      day_rollover_q <= 1'b0;
    end else begin
      state          <= state_next;
      phase          <= phase_next;
      blink_hide_q   <= hide_next;
      day_rollover_q <= (state == RUN) && hr_wrap;
    end
  end

  // Next mode, blink phase and mask; mode_btn takes priority over inc_btn
  always_comb begin
    state_next = state;
    phase_next = phase;
    inc_accept = 1'b0;
    hide_next  = '0;

    if (bus.mode_btn) begin
      phase_next = 1'b0;
      case (state)
        RUN:     state_next = SET_H;
        SET_H:   state_next = SET_M;
        SET_M:   state_next = SET_S;
        default: state_next = RUN;
      endcase
    end else if (state != RUN) begin
      if (bus.inc_btn) begin
        inc_accept = 1'b1;
        phase_next = 1'b0;
      end else if (bus.tick) begin
        phase_next = ~phase;
      end
    end

    case (state_next)
      SET_H:   hide_next[HOUR_BIT] = phase_next;
      SET_M:   hide_next[MIN_BIT]  = phase_next;
      SET_S:   hide_next[SEC_BIT]  = phase_next;
      default: hide_next           = '0;
    endcase
  end

  // Carries only ripple in RUN; SET modes step the selected field alone
  assign sec_inc = ((state == RUN) && bus.tick) || ((state == SET_S) && inc_accept);
  assign min_inc = ((state == RUN) && sec_wrap) || ((state == SET_M) && inc_accept);
  assign hr_inc  = ((state == RUN) && min_wrap) || ((state == SET_H) && inc_accept);

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .value(sec_v), .wrap_c(sec_wrap)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .value(min_v), .wrap_c(min_wrap)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .value(hr_v), .wrap_c(hr_wrap)
  );

  assign bus.seconds      = sec_v;
  assign bus.minutes      = min_v;
  assign bus.hours        = hr_v;
  assign bus.mode         = MODE_W'(state);
  assign bus.blink_hide   = blink_hide_q;
  assign bus.day_rollover = day_rollover_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random stimulus,
// compared every cycle against a seconds-of-day reference model.
module tb_clock_set_controller;

  localparam int HOUR_MOD = 24;
  localparam int DAY      = HOUR_MOD * 3600;

  logic clk = 1'b0;
  logic reset;

  clock_set_controller_if bus ();

  clock_set_controller #(.HOUR_MOD(HOUR_MOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds since midnight, mode 0..3, blink phase
  int m_time  = 0;
  int m_mode  = 0;
  int m_phase = 0;
  int m_roll  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [31:0] exp_hide();
    if (m_mode == 0) return 32'd0;
    return 32'(m_phase) << (3 - m_mode);
  endfunction

  task automatic model_reset();
    m_time  = 0;
    m_mode  = 0;
    m_phase = 0;
    m_roll  = 0;
  endtask

  task automatic model_tick_time();
    m_time = (m_time + 1) % DAY;
    m_roll = (m_time == 0) ? 1 : 0;
  endtask

  task automatic model_update(input logic t, input logic mb, input logic ib);
    int h, mi, s;
    m_roll = 0;
    if (mb) begin
      if (m_mode == 0 && t) model_tick_time();
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
    end else if (m_mode == 0) begin
      if (t) model_tick_time();
    end else if (ib) begin
      h  = m_time / 3600;
      mi = (m_time / 60) % 60;
      s  = m_time % 60;
      case (m_mode)
        1:       h  = (h + 1) % HOUR_MOD;
        2:       mi = (mi + 1) % 60;
        default: s  = (s + 1) % 60;
      endcase
      m_time  = h * 3600 + mi * 60 + s;
      m_phase = 0;
    end else if (t) begin
      m_phase = m_phase ^ 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_hours"},   32'(bus.hours),        to_bcd(m_time / 3600));
    check({tag, "_minutes"}, 32'(bus.minutes),      to_bcd((m_time / 60) % 60));
    check({tag, "_seconds"}, 32'(bus.seconds),      to_bcd(m_time % 60));
    check({tag, "_mode"},    32'(bus.mode),         32'(m_mode));
    check({tag, "_blink"},   32'(bus.blink_hide),   exp_hide());
    check({tag, "_roll"},    32'(bus.day_rollover), 32'(m_roll));
  endtask

  // Called at a falling edge; applies one cycle of inputs and checks the result
  task automatic step(input logic t, input logic mb, input logic ib, input string tag);
    bus.tick     = t;
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    @(posedge clk);
    model_update(t, mb, ib);
    @(negedge clk);
    bus.tick     = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("rst");
    reset = 1'b1;
  endtask

  task automatic incs(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    reset        = 1'b0;
    bus.tick     = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Basic count: 60 ticks
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, "basic");
    check("basic_min_const", 32'(bus.minutes), 32'h01);
    check("basic_sec_const", 32'(bus.seconds), 32'h00);

    // Day rollover from 23:59:59
    pulse_reset();
    step(1'b0, 1'b1, 1'b0, "set");
    incs(23, "set_h");
    step(1'b0, 1'b1, 1'b0, "set");
    incs(59, "set_m");
    step(1'b0, 1'b1, 1'b0, "set");
    incs(59, "set_s");
    step(1'b0, 1'b1, 1'b0, "set");
    check("pre_roll_hours", 32'(bus.hours), 32'h23);
    step(1'b1, 1'b0, 1'b0, "roll");
    check("roll_hours_const", 32'(bus.hours), 32'h00);
    check("roll_pulse_const", 32'(bus.day_rollover), 32'd1);
    step(1'b0, 1'b0, 1'b0, "roll_after");
    check("roll_low_const", 32'(bus.day_rollover), 32'd0);

    // Hour field wrap with interleaved ticks
    step(1'b0, 1'b1, 1'b0, "hwrap");
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b1, "hwrap");
      step(1'b1, 1'b0, 1'b0, "hwrap");
    end
    check("hwrap_hours_const", 32'(bus.hours), 32'h01);

    // Blink phase in SET_H
    pulse_reset();
    step(1'b0, 1'b1, 1'b0, "blink");
    step(1'b1, 1'b0, 1'b0, "blink");
    check("blink_1tick", 32'(bus.blink_hide), 32'b100);
    step(1'b1, 1'b0, 1'b0, "blink");
    check("blink_2tick", 32'(bus.blink_hide), 32'b000);
    step(1'b1, 1'b0, 1'b0, "blink");
    check("blink_3tick", 32'(bus.blink_hide), 32'b100);
    step(1'b0, 1'b0, 1'b1, "blink");
    check("blink_inc", 32'(bus.blink_hide), 32'b000);

    // Mode priority in SET_M at minutes 34
    step(1'b0, 1'b1, 1'b0, "prio");
    incs(34, "prio");
    step(1'b0, 1'b1, 1'b1, "prio");
    check("prio_mode_const", 32'(bus.mode), 32'b11);
    check("prio_min_const", 32'(bus.minutes), 32'h34);

    // SET_S mode+tick returns to RUN uncounted; RUN mode+tick counts
    step(1'b1, 1'b1, 1'b0, "sets_tick");
    step(1'b1, 1'b1, 1'b0, "run_tick");
    check("run_tick_mode_const", 32'(bus.mode), 32'b01);

    // Asynchronous reset mid-set at 12:34:00
    pulse_reset();
    step(1'b0, 1'b1, 1'b0, "mid");
    incs(12, "mid");
    step(1'b0, 1'b1, 1'b0, "mid");
    incs(34, "mid");
    check("mid_pre_hours", 32'(bus.hours), 32'h12);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_hours", 32'(bus.hours), 32'h00);
    check("async_minutes", 32'(bus.minutes), 32'h00);
    check("async_seconds", 32'(bus.seconds), 32'h00);
    check("async_mode", 32'(bus.mode), 32'b00);
    check("async_blink", 32'(bus.blink_hide), 32'b000);
    @(negedge clk);
    reset = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
